// File: rtl/sprite_compositor.sv
// Priority compositor for N sprite layers: CLUT lookup, blanking, 2-cycle sync-aligned RGB,
// frame-synchronised position/enable registers and per-frame collision flags.
module sprite_compositor #(
    parameter int               NSPR       = 4,
    parameter int               CORDW      = 16,
    parameter int               CIDXW      = 4,
    parameter logic [CIDXW-1:0] TRANS_INDX = '1,
    parameter logic [11:0]      BG_COLR    = 12'h137,
    parameter logic             SYNC_IDLE  = 1'b1
) (
    input  logic                    clk_25MHz,
    input  logic                    btn_rst_n,
    input  logic                    bright,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    frame,
    input  logic [NSPR*CIDXW-1:0]   spr_pix,
    input  logic [NSPR-1:0]         spr_drawing,
    input  logic                    reg_we,
    input  logic [7:0]              reg_addr,
    input  logic [15:0]             reg_wdata,
    output logic [NSPR*CORDW-1:0]   sprx,
    output logic [NSPR*CORDW-1:0]   spry,
    output logic [NSPR-1:0]         coll_status,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b
);
    localparam int NCLUT = 2**CIDXW;

    logic [NSPR-1:0][CORDW-1:0] shx, shy, shx_nxt, shy_nxt, livex, livey;
    logic [NSPR-1:0]            en_sh, en_sh_nxt, en_live;
    logic [11:0]                clut [NCLUT];
    logic [11:0]                bg;
    logic [NSPR-1:0]            opaque, coll_now, coll_acc;
    logic [CIDXW-1:0]           win_idx, win_idx_d1;
    logic                       hit, hit_d1, bright_d1, hsync_d1, vsync_d1;
    logic                       clut_we;
    logic [11:0]                colr;

    // Shadow next-state includes this cycle's write so a write coinciding with frame is copied.
    always_comb begin
        shx_nxt   = shx;
        shy_nxt   = shy;
        en_sh_nxt = en_sh;
        if (reg_we) begin
            for (int i = 0; i < NSPR; i++) begin
                if (reg_addr == 8'(2*i))   shx_nxt[i] = reg_wdata[CORDW-1:0];
                if (reg_addr == 8'(2*i+1)) shy_nxt[i] = reg_wdata[CORDW-1:0];
            end
            if (reg_addr == 8'h61) en_sh_nxt = reg_wdata[NSPR-1:0];
        end
    end

    assign clut_we = reg_we && (reg_addr >= 8'h40) && (int'(reg_addr) < 64 + NCLUT);

    always_comb begin
        opaque   = '0;
        coll_now = '0;
        win_idx  = '0;
        hit      = 1'b0;
        for (int i = 0; i < NSPR; i++)
            opaque[i] = spr_drawing[i] && en_live[i] &&
                        (spr_pix[i*CIDXW +: CIDXW] != TRANS_INDX);
        // Walk from lowest priority upward so layer 0 is the last to overwrite.
        for (int i = NSPR-1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_idx = spr_pix[i*CIDXW +: CIDXW];
                hit     = 1'b1;
            end
        end
        for (int i = 0; i < NSPR; i++)
            coll_now[i] = bright && opaque[i] && |(opaque & ~(NSPR'(1) << i));
    end

    always_comb begin
        colr = 12'h000;
        if (bright_d1) colr = hit_d1 ? clut[win_idx_d1] : bg;
    end

    always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            shx         <= '0;
            shy         <= '0;
            livex       <= '0;
            livey       <= '0;
            en_sh       <= '1;
            en_live     <= '1;
            bg          <= BG_COLR;
            for (int j = 0; j < NCLUT; j++) clut[j] <= 12'h000;
            coll_acc    <= '0;
            coll_status <= '0;
            win_idx_d1  <= '0;
            hit_d1      <= 1'b0;
            bright_d1   <= 1'b0;
            hsync_d1    <= SYNC_IDLE;
            vsync_d1    <= SYNC_IDLE;
            vga_hsync   <= SYNC_IDLE;
            vga_vsync   <= SYNC_IDLE;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
        end else begin
            shx   <= shx_nxt;
            shy   <= shy_nxt;
            en_sh <= en_sh_nxt;
            if (frame) begin
                livex       <= shx_nxt;
                livey       <= shy_nxt;
                en_live     <= en_sh_nxt;
                coll_status <= coll_acc;
                coll_acc    <= coll_now;
            end else begin
                coll_acc    <= coll_acc | coll_now;
            end
            if (clut_we) clut[reg_addr[CIDXW-1:0]] <= reg_wdata[11:0];
            if (reg_we && reg_addr == 8'h60) bg <= reg_wdata[11:0];

            win_idx_d1 <= win_idx;
            hit_d1     <= hit;
            bright_d1  <= bright;
            hsync_d1   <= hsync;
            vsync_d1   <= vsync;

            vga_hsync  <= hsync_d1;
            vga_vsync  <= vsync_d1;
            vga_r      <= {colr[11:8], colr[11:8]};
            vga_g      <= {colr[7:4],  colr[7:4]};
            vga_b      <= {colr[3:0],  colr[3:0]};
        end
    end

    assign sprx = livex;
    assign spry = livey;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random traffic against a cycle-level model.
module tb_sprite_compositor;
    logic        clk_25MHz = 1'b0;
    logic        btn_rst_n = 1'b1;
    logic        bright = 1'b0, hsync = 1'b1, vsync = 1'b1, frame = 1'b0;
    logic [15:0] spr_pix = 16'hFFFF;
    logic [3:0]  spr_drawing = 4'h0;
    logic        reg_we = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [15:0] reg_wdata = 16'h0000;
    logic [63:0] sprx, spry;
    logic [3:0]  coll_status;
    logic        vga_hsync, vga_vsync;
    logic [7:0]  vga_r, vga_g, vga_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_on = 1'b0;

    // model state
    logic [11:0] m_clut [16];
    logic [11:0] m_bg;
    logic [15:0] m_shx [4], m_shy [4], m_lx [4], m_ly [4];
    logic [3:0]  m_en_sh, m_en_live, m_acc, m_coll;
    logic [3:0]  p_idx;
    logic        p_hit, p_bright, p_hs, p_vs;
    logic [7:0]  e_r, e_g, e_b;
    logic        e_hs, e_vs;
    logic [63:0] e_sprx, e_spry;
    logic [3:0]  e_coll;

    always #20 clk_25MHz = ~clk_25MHz;

    sprite_compositor dut (
        .clk_25MHz(clk_25MHz), .btn_rst_n(btn_rst_n), .bright(bright),
        .hsync(hsync), .vsync(vsync), .frame(frame),
        .spr_pix(spr_pix), .spr_drawing(spr_drawing),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .sprx(sprx), .spry(spry), .coll_status(coll_status),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_25MHz) begin
        if (chk_on) begin
            chk("vga_r", {56'h0, vga_r}, {56'h0, e_r});
            chk("vga_g", {56'h0, vga_g}, {56'h0, e_g});
            chk("vga_b", {56'h0, vga_b}, {56'h0, e_b});
            chk("vga_hsync", {63'h0, vga_hsync}, {63'h0, e_hs});
            chk("vga_vsync", {63'h0, vga_vsync}, {63'h0, e_vs});
            chk("sprx", sprx, e_sprx);
            chk("spry", spry, e_spry);
            chk("coll_status", {60'h0, coll_status}, {60'h0, e_coll});
        end
    end

    task automatic model_reset();
        for (int j = 0; j < 16; j++) m_clut[j] = 12'h000;
        for (int i = 0; i < 4; i++) begin
            m_shx[i] = 0; m_shy[i] = 0; m_lx[i] = 0; m_ly[i] = 0;
        end
        m_bg = 12'h137; m_en_sh = 4'hF; m_en_live = 4'hF; m_acc = 0; m_coll = 0;
        p_idx = 0; p_hit = 0; p_bright = 0; p_hs = 1; p_vs = 1;
        e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1;
        e_sprx = 0; e_spry = 0; e_coll = 0;
    endtask

    // One pixel clock: inputs set by the caller are applied, model advances, expectations refresh.
    task automatic step();
        logic [11:0] col;
        logic [3:0]  op, idx, cnew;
        logic        hit;
        hsync = 1'($urandom);
        vsync = 1'($urandom);
        col = !p_bright ? 12'h000 : (p_hit ? m_clut[p_idx] : m_bg);
        op = 0;
        for (int i = 0; i < 4; i++)
            op[i] = spr_drawing[i] && m_en_live[i] && (spr_pix[i*4 +: 4] != 4'hF);
        hit = 0; idx = 0;
        for (int i = 0; i < 4; i++)
            if (op[i] && !hit) begin hit = 1; idx = spr_pix[i*4 +: 4]; end
        for (int i = 0; i < 4; i++)
            cnew[i] = bright && op[i] && ($countones(op) >= 2);
        if (reg_we) begin
            if (reg_addr < 8'd8) begin
                if (reg_addr[0]) m_shy[reg_addr[2:1]] = reg_wdata;
                else             m_shx[reg_addr[2:1]] = reg_wdata;
            end else if (reg_addr >= 8'h40 && reg_addr < 8'h50) m_clut[reg_addr[3:0]] = reg_wdata[11:0];
            else if (reg_addr == 8'h60) m_bg = reg_wdata[11:0];
            else if (reg_addr == 8'h61) m_en_sh = reg_wdata[3:0];
        end
        if (frame) begin
            for (int i = 0; i < 4; i++) begin m_lx[i] = m_shx[i]; m_ly[i] = m_shy[i]; end
            m_en_live = m_en_sh;
            m_coll = m_acc;
            m_acc = cnew;
        end else begin
            m_acc = m_acc | cnew;
        end
        @(posedge clk_25MHz); #1;
        e_r = {col[11:8], col[11:8]};
        e_g = {col[7:4], col[7:4]};
        e_b = {col[3:0], col[3:0]};
        e_hs = p_hs; e_vs = p_vs;
        for (int i = 0; i < 4; i++) begin
            e_sprx[i*16 +: 16] = m_lx[i];
            e_spry[i*16 +: 16] = m_ly[i];
        end
        e_coll = m_coll;
        p_idx = idx; p_hit = hit; p_bright = bright; p_hs = hsync; p_vs = vsync;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic f);
        reg_we = 1; reg_addr = a; reg_wdata = d; frame = f;
        step();
        reg_we = 0; frame = 0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #5 btn_rst_n = 0;
        #1;
        chk("rst_r", {56'h0, vga_r}, 64'h0);
        chk("rst_hsync", {63'h0, vga_hsync}, 64'h1);
        chk("rst_sprx", sprx, 64'h0);
        @(posedge clk_25MHz); #1;
        btn_rst_n = 1;
        model_reset();
        chk_on = 1;
        bright = 1;
        steps(3);
        chk("bg_r", {56'h0, vga_r}, 64'h11);
        chk("bg_g", {56'h0, vga_g}, 64'h33);
        chk("bg_b", {56'h0, vga_b}, 64'h77);

        wr(8'h45, 16'h0F80, 0);
        spr_pix = 16'hF5FF; spr_drawing = 4'b0100;
        steps(2);
        chk("clut5_r", {56'h0, vga_r}, 64'hFF);
        chk("clut5_g", {56'h0, vga_g}, 64'h88);
        chk("clut5_b", {56'h0, vga_b}, 64'h00);
        bright = 0;
        steps(2);
        chk("blank_r", {56'h0, vga_r}, 64'h00);

        bright = 1;
        wr(8'h43, 16'h00A1, 0);
        spr_pix = 16'hFF53; spr_drawing = 4'b0011;
        steps(2);
        chk("prio_g", {56'h0, vga_g}, 64'hAA);
        chk("prio_b", {56'h0, vga_b}, 64'h11);
        wr(8'h61, 16'h000E, 1);
        steps(2);
        chk("en_off_g", {56'h0, vga_g}, 64'h88);
        wr(8'h61, 16'h000F, 1);
        spr_pix = 16'hFF5F;
        steps(2);
        chk("trans_r", {56'h0, vga_r}, 64'hFF);

        spr_drawing = 0;
        wr(8'h02, 16'd100, 0);
        step();
        chk("sprx1_hold", {48'h0, sprx[31:16]}, 64'd0);
        frame = 1; step(); frame = 0;
        chk("sprx1_live", {48'h0, sprx[31:16]}, 64'd100);
        wr(8'h04, 16'd55, 1);
        chk("sprx2_same", {48'h0, sprx[47:32]}, 64'd55);

        frame = 1; step(); frame = 0;
        spr_pix = 16'h5F3F; spr_drawing = 4'b1010;
        step();
        spr_drawing = 0;
        step();
        frame = 1; step(); frame = 0;
        chk("coll_1010", {60'h0, coll_status}, 64'b1010);
        step();
        frame = 1; step(); frame = 0;
        chk("coll_clear", {60'h0, coll_status}, 64'h0);

        for (int k = 0; k < 3000; k++) begin
            bright = ($urandom_range(0, 3) != 0);
            frame = ($urandom_range(0, 49) == 0);
            spr_drawing = 4'($urandom);
            spr_pix = 16'($urandom);
            reg_we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: reg_addr = 8'($urandom_range(0, 7));
                1: reg_addr = 8'(8'h40 + $urandom_range(0, 15));
                2: reg_addr = 8'h60;
                3: reg_addr = 8'h61;
                default: reg_addr = 8'($urandom);
            endcase
            reg_wdata = 16'($urandom);
            step();
        end
        reg_we = 0; frame = 0;

        #10;
        chk_on = 0;
        btn_rst_n = 0;
        #1;
        chk("mrst_r", {56'h0, vga_r}, 64'h0);
        chk("mrst_b", {56'h0, vga_b}, 64'h0);
        chk("mrst_vsync", {63'h0, vga_vsync}, 64'h1);
        chk("mrst_sprx", sprx, 64'h0);
        @(posedge clk_25MHz); #1;
        btn_rst_n = 1;
        model_reset();
        chk_on = 1;
        bright = 1; spr_pix = 16'hF5FF; spr_drawing = 4'b0100;
        steps(2);
        chk("clut_cleared", {40'h0, vga_r, vga_g, vga_b}, 64'h0);
        spr_drawing = 0;
        steps(2);
        chk("bg_restored", {40'h0, vga_r, vga_g, vga_b}, 64'h113377);
        chk_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-layer pixel compositor between the sprite engines and the VGA pins, running in the 25 MHz pixel domain. Each cycle it resolves the highest-priority opaque sprite pixel, maps it through a CPU-writable colour lookup table, and drives blanked, sync-aligned 8-bit RGB. It also holds per-sprite position and enable registers, double-buffered to frame boundaries, and reports per-sprite collisions once per frame.

## Interface
- NSPR, 4: sprite layer count (1..16); layer 0 has the highest priority.
- CORDW, 16: signed coordinate width.
- CIDXW, 4: colour index width; the CLUT has 2**CIDXW entries of 12 bits (4R:4G:4B).
- TRANS_INDX, 2**CIDXW-1: transparent colour index.
- BG_COLR, 'h137: reset value of the background colour register.
- SYNC_IDLE, 1: reset and idle level of the sync outputs.

Ports:
- clk_25MHz  in  1  pixel clock.
- btn_rst_n  in  1  asynchronous, active-low reset.
- bright  in  1  active-video flag from vga_control.
- hsync, vsync  in  1 each  raw syncs from vga_control.
- frame  in  1  one-cycle pulse at frame start.
- spr_pix  in  NSPR*CIDXW  per-layer colour index; layer i occupies [i*CIDXW +: CIDXW].
- spr_drawing  in  NSPR  per-layer drawing flag.
- reg_we  in  1  register write strobe.
- reg_addr  in  8  register address.
- reg_wdata  in  16  write data.
- sprx, spry  out  NSPR*CORDW each  live sprite positions to the sprite instances.
- coll_status  out  NSPR  per-layer collision flags for the previous frame.
- vga_hsync, vga_vsync  out  1 each  delayed syncs.
- vga_r, vga_g, vga_b  out  8 each  colour outputs.

## Operation
- Address map:
  - 2i: sprx shadow of layer i.
  - 2i+1: spry shadow of layer i.
  - i < NSPR; addresses in 0x00..0x3F.
  - 0x40+j: CLUT entry j, data bits [11:0].
  - 0x60: background colour, data bits [11:0].
  - 0x61: layer enable mask, data bits [NSPR-1:0].
  - Any other address: write ignored.
- Write behaviour:
  - Position and enable writes go to shadow registers.
  - On a `frame` pulse, all shadows copy to the live registers. A write in the same cycle as `frame` is included in the copy.
  - CLUT and background writes take effect immediately.
- Layer i is opaque when spr_drawing[i] is high, its live enable bit is set, and its index is not TRANS_INDX.
- The winner is the lowest-numbered opaque layer. hit = at least one layer is opaque.
- Output colour:
  - bright_d1 = 0: 0.
  - hit_d1 = 1: CLUT[winner index].
  - Otherwise: the background register.
  - Each 4-bit channel c expands to {c,c}, so 'hF gives 'hFF and 'h3 gives 'h33.
- Collisions:
  - While bright is high, layer i's accumulator bit sets when layer i is opaque and any other layer is opaque in the same cycle.
  - On `frame`, coll_status takes the accumulator value and the accumulator clears. A collision in the `frame` cycle itself counts toward the new frame.
- Reset values:
  - sprx, spry, all shadows: 0.
  - Enable mask: all ones.
  - CLUT: 0.
  - Background: BG_COLR.
  - coll_status and accumulator: 0.
  - vga_r, vga_g, vga_b: 0.
  - vga_hsync, vga_vsync: SYNC_IDLE.

## Timing
- Pipeline:
  - Edge 1 registers the winner index, hit, bright and the syncs.
  - Edge 2 registers the CLUT/background/blank result and the delayed syncs to the outputs.
  - Pixel-input-to-output latency is exactly 2 cycles; syncs are delayed by the same 2 cycles.
- CLUT write at edge k:
  - Visible to a stage-2 lookup from edge k+1 onward.
  - A lookup at edge k itself returns the old value.
- Shadow-to-live copy completes at the `frame` edge; the new sprx/spry are visible the following cycle.
- reg_we has no handshake: one write per cycle, always accepted.
- Asynchronous reset mid-frame forces all reset values immediately. Output resumes 2 cycles after the first cycle following reset release.

## Test plan
- Reset then idle with bright=1, no drawing: after 2 cycles, RGB = 'h11,'h33,'h77 (BG_COLR 'h137); syncs follow the inputs delayed by 2 cycles.
- Write CLUT[5]='hF80, drive layer 2 with pix 5 and drawing: RGB = 'hFF,'h88,'h00 two cycles later. With bright=0, RGB = 0.
- Layers 0 and 1 opaque with indices 3 and 5: layer 0's colour is output. Clear enable bit 0 then pulse frame: layer 1's colour is output. Layer 0 with pix=TRANS_INDX: falls through to layer 1.
- Write sprx[1]=100 mid-frame: the sprx output stays unchanged until `frame`, then reads 100. A write coinciding with `frame` reads the new value the next cycle.
- Layers 1 and 3 overlap opaquely for one visible cycle: after the next frame pulse coll_status = 'b1010; after another frame with no overlap, coll_status = 0.
- Assert btn_rst_n low mid-line: outputs go to 0/SYNC_IDLE without waiting for a clock edge, and the CLUT and positions return to their reset values.
